// File: rtl/door_lock_ctrl.sv
// door_lock_ctrl: keypad passcode entry controller producing the STAGE1 door lock flag
//   clk, rst_n       : clock, asynchronous active-low reset
//   state            : game FSM state; anything other than STAGE1_ID re-arms the lock
//   key_valid/code   : keypad strobe and code (0-9 digit, E backspace, F enter)
//   isLocked         : door locked flag for the door drawer
//   entered/digit_cnt: BCD digits held (newest in [3:0]) and their count
//   tries_left       : remaining attempts before lockout
//   err_flash        : high during the error window
//   unlock_pulse/fail_pulse : one-cycle result strobes
module door_lock_ctrl #(
  parameter logic [15:0] CODE       = 16'h1234,
  parameter int          MAX_TRIES  = 3,
  parameter int          ERR_CYCLES = 50_000_000,
  parameter logic [3:0]  STAGE1_ID  = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        isLocked,
  output logic [15:0] entered,
  output logic [2:0]  digit_cnt,
  output logic [1:0]  tries_left,
  output logic        err_flash,
  output logic        unlock_pulse,
  output logic        fail_pulse
);
  localparam int CW = ERR_CYCLES > 1 ? $clog2(ERR_CYCLES) : 1;
  localparam logic [CW-1:0] ERR_LAST = CW'(ERR_CYCLES - 1);
  localparam logic [2:0] LOCKED = 3'd0, CHECK = 3'd1, OPEN = 3'd2, ERROR = 3'd3, LOCKOUT = 3'd4;
  logic [2:0] fsm;
  logic [CW-1:0] err_cnt;
  logic is_digit;
  assign is_digit = key_code <= 4'd9;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= LOCKED;
      isLocked <= 1'b1;
      entered <= '0;
      digit_cnt <= '0;
      tries_left <= 2'(MAX_TRIES);
      err_flash <= 1'b0;
      unlock_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      err_cnt <= '0;
    end else if (state != STAGE1_ID) begin
      fsm <= LOCKED;
      isLocked <= 1'b1;
      entered <= '0;
      digit_cnt <= '0;
      tries_left <= 2'(MAX_TRIES);
      err_flash <= 1'b0;
      unlock_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      err_cnt <= '0;
    end else begin
      unlock_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      case (fsm)
        LOCKED: if (key_valid) begin
          if (is_digit && digit_cnt < 3'd4) begin
            entered <= {entered[11:0], key_code};
            digit_cnt <= digit_cnt + 3'd1;
          end else if (key_code == 4'hE && digit_cnt != 3'd0) begin
            entered <= {4'h0, entered[15:4]};
            digit_cnt <= digit_cnt - 3'd1;
          end else if (key_code == 4'hF && digit_cnt == 3'd4) begin
            fsm <= CHECK;
          end
        end
        CHECK: if (entered == CODE) begin
          fsm <= OPEN;
          isLocked <= 1'b0;
          unlock_pulse <= 1'b1;
        end else begin
          fail_pulse <= 1'b1;
          tries_left <= tries_left - 2'd1;
          if (tries_left == 2'd1) fsm <= LOCKOUT;
          else begin
            fsm <= ERROR;
            err_flash <= 1'b1;
            err_cnt <= '0;
          end
        end
        ERROR: if (err_cnt == ERR_LAST) begin
          fsm <= LOCKED;
          err_flash <= 1'b0;
          entered <= '0;
          digit_cnt <= '0;
          err_cnt <= '0;
        end else begin
          err_cnt <= err_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb_door_lock_ctrl: directed and random checks of door_lock_ctrl against a digit-list model
module tb_door_lock_ctrl;
  localparam int ERR = 8;
  localparam int TRIES = 3;
  localparam logic [15:0] PASS = 16'h1234;
  logic clk = 0, rst_n = 0, key_valid = 0;
  logic [3:0] state = 4'd2, key_code = 0;
  logic is_locked, err_flash, unlock_pulse, fail_pulse;
  logic [15:0] entered;
  logic [2:0] digit_cnt;
  logic [1:0] tries_left;
  int checks = 0, errors = 0;
  int digits[$];
  int m_tries, err_left;
  bit opened, lockout, checking, m_up, m_fp;

  door_lock_ctrl #(.CODE(PASS), .MAX_TRIES(TRIES), .ERR_CYCLES(ERR), .STAGE1_ID(4'd2)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .key_valid(key_valid), .key_code(key_code),
    .isLocked(is_locked), .entered(entered), .digit_cnt(digit_cnt), .tries_left(tries_left),
    .err_flash(err_flash), .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse));

  always #5 clk = ~clk;

  function automatic logic [15:0] packed_digits();
    logic [15:0] v = 0;
    foreach (digits[i]) v = (v << 4) | 16'(digits[i]);
    return v;
  endfunction

  task automatic model_reset();
    digits.delete();
    m_tries = TRIES;
    err_left = 0;
    opened = 0; lockout = 0; checking = 0; m_up = 0; m_fp = 0;
  endtask

  task automatic model_step(input bit rearm, input bit v, input int c);
    if (rearm) begin
      model_reset();
      return;
    end
    m_up = 0; m_fp = 0;
    if (checking) begin
      checking = 0;
      if (packed_digits() == PASS) begin opened = 1; m_up = 1; end
      else begin
        m_tries--; m_fp = 1;
        if (m_tries == 0) lockout = 1; else err_left = ERR;
      end
    end else if (err_left > 0) begin
      err_left--;
      if (err_left == 0) digits.delete();
    end else if (!opened && !lockout && v) begin
      if (c <= 9) begin if (digits.size() < 4) digits.push_back(c); end
      else if (c == 14) begin if (digits.size() > 0) void'(digits.pop_back()); end
      else if (c == 15 && digits.size() == 4) checking = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("isLocked", 16'(is_locked), 16'(!opened));
    chk("entered", entered, packed_digits());
    chk("digit_cnt", 16'(digit_cnt), 16'(digits.size()));
    chk("tries_left", 16'(tries_left), 16'(m_tries));
    chk("err_flash", 16'(err_flash), 16'(err_left > 0));
    chk("unlock_pulse", 16'(unlock_pulse), 16'(m_up));
    chk("fail_pulse", 16'(fail_pulse), 16'(m_fp));
  endtask

  task automatic cyc(input logic v, input logic [3:0] c);
    key_valid = v; key_code = c;
    @(posedge clk);
    model_step(state != 4'd2, v, int'(c));
    #1;
    key_valid = 0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'h0);
  endtask

  task automatic type_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) cyc(1, code[i*4 +: 4]);
    cyc(1, 4'hF);
  endtask

  initial begin
    model_reset();
    #12 check_all();
    rst_n = 1;
    idle(2);
    type_code(16'h1234);
    cyc(0, 0);
    chk("open_locked", 16'(is_locked), 16'h0);
    chk("open_pulse", 16'(unlock_pulse), 16'h1);
    cyc(1, 4'h5); cyc(1, 4'hE); cyc(1, 4'hF);
    state = 4'd4; cyc(1, 4'h7);
    state = 4'd2; cyc(1, 4'h8);
    chk("rearm_locked", 16'(is_locked), 16'h1);
    chk("rearm_tries", 16'(tries_left), 16'h3);
    idle(1);
    type_code(16'h1235);
    cyc(1, 4'h3);
    chk("wrong_fail", 16'(fail_pulse), 16'h1);
    chk("wrong_tries", 16'(tries_left), 16'h2);
    for (int i = 0; i < ERR + 2; i++) cyc(1, 4'(i % 10));
    type_code(16'h1111); idle(ERR + 1);
    chk("second_tries", 16'(tries_left), 16'h1);
    type_code(16'h4321); idle(2);
    chk("lockout_tries", 16'(tries_left), 16'h0);
    chk("lockout_flash", 16'(err_flash), 16'h0);
    type_code(16'h1234); idle(2);
    chk("lockout_locked", 16'(is_locked), 16'h1);
    state = 4'd0; cyc(0, 0);
    state = 4'd2; cyc(0, 0);
    cyc(1, 4'h9); cyc(1, 4'h8); cyc(1, 4'hE);
    cyc(1, 4'h1); cyc(1, 4'h2); cyc(1, 4'h3); cyc(1, 4'h4); cyc(1, 4'h7);
    chk("edit_entered", entered, 16'h9123);
    cyc(1, 4'hF); cyc(0, 0);
    chk("edit_fail", 16'(fail_pulse), 16'h1);
    idle(ERR);
    cyc(1, 4'h1); cyc(1, 4'h2); cyc(1, 4'h3); cyc(1, 4'hF); idle(2);
    chk("short_enter_tries", 16'(tries_left), 16'h2);
    cyc(1, 4'hA); cyc(1, 4'hE); cyc(1, 4'hE); cyc(1, 4'hE); cyc(1, 4'hE);
    type_code(16'h5678); idle(3);
    #3 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("async_flash", 16'(err_flash), 16'h0);
    #3 rst_n = 1;
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      int r;
      state = ($urandom_range(0, 199) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      r = $urandom_range(0, 9);
      c = (r < 5) ? 4'($urandom_range(1, 5)) : (r < 7) ? 4'hF : (r < 8) ? 4'hE : 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), c);
    end
    state = 4'd2;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Sequential keypad-entry controller that produces the `isLocked` flag consumed by the door sprite drawer in the STAGE1 scene. It collects four decimal digits from the keypad decoder, compares them against a fixed passcode on Enter, and drives lock state, error flash and lockout for the VGA object layer. It is active only while the game FSM is in STAGE1 and re-arms whenever the game leaves that stage.

## Interface
- `CODE`, 16'h1234: passcode as four BCD nibbles, first-typed digit in [15:12].
- `MAX_TRIES`, 3: wrong attempts allowed before lockout; range 1..3.
- `ERR_CYCLES`, 50_000_000: length of the error-flash window in clk cycles; minimum 1.
- `STAGE1_ID`, 4'd2: game-state encoding of STAGE1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `state`  in  4  game FSM state.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`  in  4  0–9 are digits; 4'hE is backspace; 4'hF is Enter; A–D are ignored.
- `isLocked`  out  1  1 = door locked; goes to the door drawer.
- `entered`  out  16  digits typed so far as BCD, newest digit in [3:0].
- `digit_cnt`  out  3  number of digits held, 0..4.
- `tries_left`  out  2  remaining attempts.
- `err_flash`  out  1  high during the ERROR window.
- `unlock_pulse`  out  1  one-cycle strobe on a correct code.
- `fail_pulse`  out  1  one-cycle strobe on a wrong code.

## Operation
- Internal FSM states are LOCKED, CHECK, OPEN, ERROR and LOCKOUT. All outputs are registered.
- Reset values: FSM = LOCKED, `isLocked`=1, `entered`=0, `digit_cnt`=0, `tries_left`=MAX_TRIES, `err_flash`=0, both pulses 0, error counter 0.
- Re-arm: whenever `state`≠STAGE1_ID, every register is synchronously forced to its reset value. This check has priority over all key handling.
- LOCKED, digit key with `digit_cnt`<4:
  - `entered` ← {`entered`[11:0], `key_code`}.
  - `digit_cnt` increments.
  - A digit typed at count 4 is ignored.
- LOCKED, backspace with `digit_cnt`>0:
  - `entered` ← {4'h0, `entered`[15:4]}.
  - `digit_cnt` decrements.
  - Backspace at count 0 is ignored.
- LOCKED, Enter:
  - With `digit_cnt`==4, the FSM goes to CHECK.
  - With fewer than 4 digits, Enter is ignored and no attempt is consumed.
- CHECK always lasts exactly one cycle and ignores keys.
  - `entered`==CODE: go to OPEN and assert `unlock_pulse`.
  - Mismatch with `tries_left`>1: `tries_left` decrements, go to ERROR, assert `fail_pulse`.
  - Mismatch with `tries_left`==1: `tries_left`←0, go to LOCKOUT, assert `fail_pulse`.
- OPEN: `isLocked`=0. Keys are ignored. The FSM holds here until re-arm.
- ERROR:
  - `err_flash`=1 and keys are ignored.
  - The counter runs from 0 to ERR_CYCLES-1.
  - After that, the FSM goes to LOCKED with `entered`=0, `digit_cnt`=0 and `err_flash`=0.
- LOCKOUT: `isLocked`=1, `err_flash`=0, keys are ignored. The FSM holds until re-arm.
- `entered` and `digit_cnt` are left unchanged in CHECK, OPEN and LOCKOUT.

## Timing
- A `key_valid` sampled at edge t updates `entered`/`digit_cnt` at edge t, so the new values are visible in cycle t+1.
- Enter at edge t:
  - CHECK in cycle t+1.
  - OPEN, ERROR or LOCKOUT in cycle t+2, with `isLocked`, `err_flash`, `tries_left` and the pulse updated in that same cycle.
  - The pulse is high for exactly that one cycle.
- ERROR lasts exactly ERR_CYCLES cycles. The first digit after ERROR is accepted in the first LOCKED cycle.
- If `key_valid` arrives in the same cycle as re-arm, the key is dropped.
- Assertion of `rst_n` clears all state immediately, asynchronously. Deassertion is synchronised externally.

## Test plan
- Reset, then `state`=2; type 1,2,3,4, then Enter. Required: `digit_cnt` reaches 4 and `entered`=16'h1234. Two cycles after Enter, `isLocked`=0 and `unlock_pulse` is high for 1 cycle. Later keys have no effect.
- Type 1,2,3,5 then Enter, with ERR_CYCLES=8. Required: `fail_pulse` for 1 cycle, `tries_left`=2, `err_flash` high for 8 cycles, then `entered`=0 and `isLocked`=1.
- Three wrong codes. Required: `tries_left` reads 2, then 1, then 0. After the third, LOCKOUT with `err_flash`=0. A following correct code is ignored and `isLocked` stays 1.
- Editing sequence: 9,8,backspace,1,2,3,4,7 then Enter. Required: 7 is dropped, `entered`=16'h9123, and a mismatch is reported. Separately, Enter with 3 digits leaves `tries_left` unchanged.
- Unlock, then set `state`=4, then back to 2. Required: `isLocked`=1 and `tries_left`=3 on the first cycle after the change. A key strobe coincident with the state change is dropped.
- Assert `rst_n`=0 mid-ERROR. Required: all outputs return to their reset values asynchronously, before the next clk edge.
